block_serial_csa: RTL and testbench

Multi-cycle, parametrised carry-select adder/subtractor. Operands are latched on a start pulse, and one BLOCK-bit carry-select slice is resolved per clock, least significant first. The block reports sum, carry-out and signed overflow with a Run/Done handshake. It is the sequential, width-generic successor to the single-bit carry-select cell. It sits beside the ALU datapath wherever a narrow, area-cheap adder with a bounded latency is acceptable.

---
 rtl/csa_pkg.sv | 18 +
 rtl/csa_block.sv | 44 ++++
 rtl/full_adder.sv | 14 +
 rtl/block_serial_csa.sv | 107 ++++++++++
 tb/tb_block_serial_csa.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/csa_pkg.sv
// Shared types and helpers for the block-serial carry-select adder.
// Holds the FSM state encoding and the index-width function.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } csa_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/csa_block.sv
// One carry-select slice: two ripple chains, for carry-in 0 and 1.
// Also exposes the carry into the slice MSB for overflow detection.
module csa_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  output logic [BLOCK-1:0] s0,
  output logic [BLOCK-1:0] s1,
  output logic             c0,
  output logic             c1,
  output logic             cm0,
  output logic             cm1
);

  logic [BLOCK:0] k0;
  logic [BLOCK:0] k1;

  assign k0[0] = 1'b0;
  assign k1[0] = 1'b1;

  for (genvar i = 0; i < BLOCK; i++) begin : g_bit
    full_adder u_fa0 (
      .a_i(a[i]),
      .b_i(b[i]),
      .c_i(k0[i]),
      .s_o(s0[i]),
      .c_o(k0[i+1])
    );
    full_adder u_fa1 (
      .a_i(a[i]),
      .b_i(b[i]),
      .c_i(k1[i]),
      .s_o(s1[i]),
      .c_o(k1[i+1])
    );
  end

  assign c0  = k0[BLOCK];
  assign c1  = k1[BLOCK];
  assign cm0 = k0[BLOCK-1];
  assign cm1 = k1[BLOCK-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Basic ripple element for the carry-select slices.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/block_serial_csa.sv
// Sequential carry-select add/sub: one BLOCK-bit slice per clock, LSB first.
// Run/Done handshake; DONE waits for Run low so a held Run cannot retrigger.
module block_serial_csa
  import csa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf,
  output logic             Busy,
  output logic             Done
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int IW   = (clog2(NBLK) < 1) ? 1 : clog2(NBLK);
  localparam logic [IW-1:0] LAST = IW'(NBLK - 1);

  csa_state_t state_q, state_d;

  logic [NBLK-1:0][BLOCK-1:0] a_q, b_q, s_q;
  logic [IW-1:0] idx_q;
  logic carry_q, cout_q, ovf_q;

  logic [BLOCK-1:0] s0, s1, sum;
  logic c0, c1, cm0, cm1;
  logic carry_n, cm;

  csa_block #(.BLOCK(BLOCK)) u_blk (
    .a  (a_q[idx_q]),
    .b  (b_q[idx_q]),
    .s0 (s0),
    .s1 (s1),
    .c0 (c0),
    .c1 (c1),
    .cm0(cm0),
    .cm1(cm1)
  );

  assign sum     = carry_q ? s1 : s0;
  assign carry_n = c0 | (c1 & carry_q);
  assign cm      = carry_q ? cm1 : cm0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Run) state_d = ADD;
      ADD:     if (idx_q == LAST) state_d = DONE;
      DONE:    if (!Run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (Run) begin
          a_q     <= A;
          b_q     <= B ^ {WIDTH{Sub}};
          carry_q <= Sub;
          idx_q   <= '0;
          s_q     <= '0;
          cout_q  <= 1'b0;
          ovf_q   <= 1'b0;
        end
        ADD: begin
          s_q[idx_q] <= sum;
          carry_q    <= carry_n;
          idx_q      <= idx_q + IW'(1);
          // overflow: carry into the sign bit differs from carry out of it
          if (idx_q == LAST) begin
            cout_q <= carry_n;
            ovf_q  <= cm ^ carry_n;
          end
        end
        default: ;
      endcase
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;
  assign Busy = (state_q == ADD);
  assign Done = (state_q == DONE);

endmodule

// File: tb/tb_block_serial_csa.sv
// Directed table, handshake/reset sequences and random ops vs a golden model.
// Three instances: 16/4 (default), 32/8 and 8/1.
module tb_block_serial_csa;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] run, sub;
  logic [31:0] av[3], bv[3];
  logic [15:0] s16;
  logic [31:0] s32;
  logic [7:0]  s8;
  logic [2:0] co, ov, bz, dn;
  int npass = 0;
  int ntot = 0;

  always #5 clk = ~clk;

  block_serial_csa #(.WIDTH(16), .BLOCK(4)) u16 (
    .Clk(clk), .Reset(rst), .Run(run[0]), .Sub(sub[0]),
    .A(av[0][15:0]), .B(bv[0][15:0]), .S(s16), .Cout(co[0]),
    .Ovf(ov[0]), .Busy(bz[0]), .Done(dn[0])
  );

  block_serial_csa #(.WIDTH(32), .BLOCK(8)) u32 (
    .Clk(clk), .Reset(rst), .Run(run[1]), .Sub(sub[1]),
    .A(av[1]), .B(bv[1]), .S(s32), .Cout(co[1]),
    .Ovf(ov[1]), .Busy(bz[1]), .Done(dn[1])
  );

  block_serial_csa #(.WIDTH(8), .BLOCK(1)) u8 (
    .Clk(clk), .Reset(rst), .Run(run[2]), .Sub(sub[2]),
    .A(av[2][7:0]), .B(bv[2][7:0]), .S(s8), .Cout(co[2]),
    .Ovf(ov[2]), .Busy(bz[2]), .Done(dn[2])
  );

  typedef struct {
    logic        sub;
    logic [15:0] a, b, s;
    logic        c, o;
  } vec_t;

  function automatic logic [31:0] sget(int k);
    case (k)
      0:       return {16'h0, s16};
      1:       return s32;
      default: return {24'h0, s8};
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic model(int w, logic s, logic [31:0] a, logic [31:0] b,
                       output logic [31:0] es, output logic ec,
                       output logic eo);
    logic [63:0] m, aa, bb, full;
    m    = (64'd1 << w) - 64'd1;
    aa   = {32'h0, a} & m;
    bb   = s ? (~{32'h0, b} & m) : ({32'h0, b} & m);
    full = aa + bb + {63'h0, s};
    es   = full[31:0] & m[31:0];
    ec   = full[w];
    eo   = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
  endtask

  task automatic start(int k, logic s, logic [31:0] a, logic [31:0] b);
    run[k] = 1'b1;
    sub[k] = s;
    av[k]  = a;
    bv[k]  = b;
    @(posedge clk); #1;
    run[k] = 1'b0;
  endtask

  task automatic wait_done(int k, output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (!dn[k] && lat < 200) begin
      if (bz[k]) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op(int k, int nb, logic s, logic [31:0] a, logic [31:0] b,
                    logic [31:0] es, logic ec, logic eo);
    int lat, bc;
    start(k, s, a, b);
    wait_done(k, lat, bc);
    chk("latency", lat, nb);
    chk("busy_cycles", bc, nb);
    chk("S", sget(k), es);
    chk("Cout", {31'h0, co[k]}, {31'h0, ec});
    chk("Ovf", {31'h0, ov[k]}, {31'h0, eo});
    @(posedge clk); #1;
    chk("done_drop", {31'h0, dn[k]}, 32'h0);
  endtask

  initial begin
    vec_t tbl[7];
    int lat, bc, nd, busr, dnr;
    logic pb, pd;
    logic [31:0] ra, rb, es;
    logic rs, ec, eo;

    tbl[0] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};

    rst = 1'b1;
    run = '0;
    sub = '0;
    for (int k = 0; k < 3; k++) begin
      av[k] = '0;
      bv[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_S", sget(k), 32'h0);
      chk("rst_flags", {28'h0, co[k], ov[k], bz[k], dn[k]}, 32'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      op(0, 4, tbl[i].sub, {16'h0, tbl[i].a}, {16'h0, tbl[i].b},
         {16'h0, tbl[i].s}, tbl[i].c, tbl[i].o);

    // Run held high: exactly one operation and one Done interval
    run[0] = 1'b1; sub[0] = 1'b0; av[0] = 32'h1; bv[0] = 32'h2;
    busr = 0; dnr = 0; pb = 1'b0; pd = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bz[0] && !pb) busr++;
      if (dn[0] && !pd) dnr++;
      pb = bz[0];
      pd = dn[0];
    end
    chk("held_starts", busr, 1);
    chk("held_dones", dnr, 1);
    chk("held_done_level", {31'h0, dn[0]}, 32'h1);
    chk("held_S", sget(0), 32'h3);
    run[0] = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_drop", {30'h0, bz[0], dn[0]}, 32'h0);
    op(0, 4, 1'b0, 32'h0F0F, 32'h0101, 32'h1010, 1'b0, 1'b0);

    // Operand changes during ADD are ignored
    start(0, 1'b0, 32'h1111, 32'h2222);
    av[0] = '0; bv[0] = '0; sub[0] = 1'b1;
    wait_done(0, lat, bc);
    chk("latched_lat", lat, 4);
    chk("latched_S", sget(0), 32'h3333);
    chk("latched_Cout", {31'h0, co[0]}, 32'h0);
    @(posedge clk); #1;

    // Reset in the 2nd ADD cycle aborts with no Done
    start(0, 1'b0, 32'h1234, 32'h4321);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_S", sget(0), 32'h0);
    chk("abort_flags", {28'h0, co[0], ov[0], bz[0], dn[0]}, 32'h0);
    nd = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (dn[0] || bz[0]) nd++;
    end
    chk("abort_no_done", nd, 0);
    op(0, 4, 1'b0, 32'h1234, 32'h4321, 32'h5555, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(1));
      model(32, rs, ra, rb, es, ec, eo);
      op(1, 4, rs, ra, rb, es, ec, eo);
    end
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom & 32'hFF; rb = $urandom & 32'hFF;
      rs = 1'($urandom_range(1));
      model(8, rs, ra, rb, es, ec, eo);
      op(2, 8, rs, ra, rb, es, ec, eo);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
